ifetch_mem_responder: RTL and testbench
=======================================

Name: ifetch_mem_responder

Overview:
- Responder (memory side) for the instruction-fetch interface; the IFU is the initiator.
- Accepts one 64-bit fetch address per request over a valid/ready handshake.
- Reads the containing aligned 64-bit word from an internal backing array and returns the selected 32-bit instruction after a programmable latency.
- Includes a loader write port, used by the testbench/boot loader to fill the array.

Parameters:
- DEPTH_WORDS, 4096, number of 64-bit words in the backing array (power of two).
- BASE_ADDR, 64'h0000000080000000, byte address mapped to array word 0.
- LATENCY, 2, cycles spent in BUSY before the response is presented; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  64  fetch byte address.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_inst  out  32  fetched instruction.
- resp_err  out  1  misaligned or out-of-range access.
- load_en  in  1  backing-array write strobe.
- load_idx  in  $clog2(DEPTH_WORDS)  word index to write.
- load_data  in  64  word to write.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, resp_valid=0, resp_inst=0, resp_err=0, latched address=0, counter=0.
  - Backing array is not reset.
  - Asserting reset mid-operation drops any outstanding request; no response is issued for it.
- FSM states: IDLE, BUSY, RESP.
- req_ready = (state==IDLE); combinational from state only, with no dependence on req_valid.
- IDLE:
  - On req_valid&&req_ready at edge k: latch req_addr, set counter=LATENCY-1, go to BUSY.
- BUSY:
  - Each edge: if counter==0, perform the read and go to RESP; else decrement counter.
  - This gives exactly LATENCY cycles in BUSY; resp_valid is first high after edge k+LATENCY.
- Read computation:
  - off = addr - BASE_ADDR (64-bit unsigned wrap).
  - widx = off[63:3].
  - err = (addr[1:0]!=0) || (addr < BASE_ADDR) || (widx >= DEPTH_WORDS).
  - If err: resp_inst=0, resp_err=1.
  - Else: resp_inst = addr[2] ? word[63:32] : word[31:0], resp_err=0.
- RESP:
  - resp_valid=1; resp_inst and resp_err are held stable until handshake.
  - On resp_valid&&resp_ready: go to IDLE, deassert resp_valid, and hold resp_inst/resp_err values until the next read.
  - resp_ready high before RESP has no effect.
- Throughput: at most one outstanding request; minimum request-to-request spacing is LATENCY+2 cycles, achieved when resp_ready is held high.
- Loader port:
  - load_en writes load_data to array[load_idx] at the edge, in any state, including during BUSY.
  - A load to the word being read at the same edge as the BUSY→RESP read returns the OLD contents (read-before-write).
  - A load at any earlier edge is visible to the read.
- req_valid may be deasserted or req_addr changed while req_ready=0 without effect; the latched address is used.
- Counter width is 4 bits; LATENCY outside 1..15 is illegal. A simulation assertion fires at elaboration.

Test Plan:
- Load array[0]=64'hDEADBEEF_00000013, req 0x80000000 then 0x80000004, resp_ready=1, LATENCY=2 -> inst 0x00000013 then 0xDEADBEEF, err=0; each resp_valid rises exactly 2 cycles after the accept edge; accept spacing is 4 cycles.
- Misaligned req 0x80000002 and out-of-range reqs 0x7FFFFFFC and 0x80008000 (DEPTH_WORDS=4096) -> resp_inst=0, resp_err=1 for each.
- Back-pressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_inst stable, req_ready=0 throughout; accepted on the first cycle resp_ready=1, req_ready=1 the next cycle.
- Load collision: req 0x80000008, then load_en on idx 1 with 64'h1 at the BUSY→RESP edge -> old word returned; repeat the fetch -> 0x00000001.
- Reset mid-BUSY: pull rst low for 1 cycle during BUSY -> immediately resp_valid=0, req_ready=1 after release, and no stale response ever appears.
- LATENCY=1 and LATENCY=15 builds: resp_valid rises 1 and 15 cycles after the accept edge respectively, with correct data.

Source files
------------

// File: rtl/ifetch_mem_responder.sv
// Instruction-fetch memory responder: single outstanding request,
// fixed-latency read of a 64-bit backing array, loader write port.
module ifetch_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY     = 2,
  localparam int unsigned IW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_inst,
  output logic          resp_err,
  input  logic          load_en,
  input  logic [IW-1:0] load_idx,
  input  logic [63:0]   load_data
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ifetch_mem_responder: LATENCY must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0] off;
  logic [63:0] wsh;
  logic [63:0] rd_word;
  logic        rd_err;

  // Word lookup for the latched address; upper shift bits feed the range check.
  assign off     = addr_q - BASE_ADDR;
  assign wsh     = off >> 3;
  assign rd_word = mem[wsh[IW-1:0]];
  assign rd_err  = (addr_q[1:0] != 2'b00)
                || (addr_q < BASE_ADDR)
                || (wsh >= 64'(DEPTH_WORDS));

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;

  // Loader writes; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept, count down latency, read, wait for handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = rd_err;
          if (rd_err)
            inst_d = '0;
          else if (addr_q[2])
            inst_d = rd_word[63:32];
          else
            inst_d = rd_word[31:0];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Directed bench for ifetch_mem_responder at LATENCY 2, 1 and 15.
// Hand-computed expectations; one checking task.
module tb_ifetch_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req_addr;
  logic        resp_ready;
  logic        load_en;
  logic [11:0] load_idx;
  logic [63:0] load_data;

  logic        rv2, rr2, ov2, er2;
  logic        rv1, rr1, ov1, er1;
  logic        rv15, rr15, ov15, er15;
  logic [31:0] in2, in1, in15;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifetch_mem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(rv2), .req_ready(rr2), .req_addr(req_addr),
    .resp_valid(ov2), .resp_ready(resp_ready),
    .resp_inst(in2), .resp_err(er2),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );

  ifetch_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv1), .req_ready(rr1), .req_addr(req_addr),
    .resp_valid(ov1), .resp_ready(resp_ready),
    .resp_inst(in1), .resp_err(er1),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );

  ifetch_mem_responder #(.LATENCY(15)) dut15 (
    .clk(clk), .rst(rst),
    .req_valid(rv15), .req_ready(rr15), .req_addr(req_addr),
    .resp_valid(ov15), .resp_ready(resp_ready),
    .resp_inst(in15), .resp_err(er15),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input int s, input logic v);
    case (s)
      0:       rv2  = v;
      1:       rv1  = v;
      default: rv15 = v;
    endcase
  endtask

  function automatic logic rdy(input int s);
    case (s)
      0:       return rr2;
      1:       return rr1;
      default: return rr15;
    endcase
  endfunction

  function automatic logic vld(input int s);
    case (s)
      0:       return ov2;
      1:       return ov1;
      default: return ov15;
    endcase
  endfunction

  function automatic logic [32:0] outp(input int s);
    case (s)
      0:       return {er2, in2};
      1:       return {er1, in1};
      default: return {er15, in15};
    endcase
  endfunction

  task automatic load(input logic [11:0] idx, input logic [63:0] d);
    load_idx  = idx;
    load_data = d;
    load_en   = 1'b1;
    step();
    load_en   = 1'b0;
  endtask

  // Returns at #1 after the edge where resp_valid first rises.
  task automatic fetch(input int s, input logic [63:0] a,
                       output logic [31:0] inst, output logic err,
                       output int lat, output int acc);
    int n;
    logic [32:0] o;
    req_addr = a;
    set_valid(s, 1'b1);
    n = 0;
    while (!rdy(s) && n < 50) begin
      step();
      n++;
    end
    step();
    acc = cyc;
    set_valid(s, 1'b0);
    lat = 0;
    while (!vld(s) && lat < 50) begin
      step();
      lat++;
    end
    o    = outp(s);
    inst = o[31:0];
    err  = o[32];
  endtask

  logic [31:0] inst, hold;
  logic        err;
  int          lat, acc, acc0, stale;

  initial begin
    rst = 1'b0;
    rv2 = 1'b0; rv1 = 1'b0; rv15 = 1'b0;
    req_addr = '0; resp_ready = 1'b1;
    load_en = 1'b0; load_idx = '0; load_data = '0;
    repeat (3) step();
    chk("rst_req_ready", 64'(rr2), 64'd1);
    chk("rst_resp_valid", 64'(ov2), 64'd0);
    chk("rst_resp_inst", 64'(in2), 64'd0);
    chk("rst_resp_err", 64'(er2), 64'd0);
    rst = 1'b1;
    step();

    load(12'd0,    64'hDEADBEEF_00000013);
    load(12'd1,    64'hCAFEF00D_12345678);
    load(12'd2,    64'h11112222_33334444);
    load(12'd4095, 64'hA5A5A5A5_0BADF00D);

    fetch(0, 64'h8000_0000, inst, err, lat, acc0);
    chk("lo_inst", 64'(inst), 64'h13);
    chk("lo_err", 64'(err), 64'd0);
    chk("lo_lat", 64'(lat), 64'd2);
    fetch(0, 64'h8000_0004, inst, err, lat, acc);
    chk("hi_inst", 64'(inst), 64'hDEADBEEF);
    chk("hi_err", 64'(err), 64'd0);
    chk("hi_lat", 64'(lat), 64'd2);
    chk("spacing", 64'(acc - acc0), 64'd4);

    fetch(0, 64'h8000_0002, inst, err, lat, acc);
    chk("mis_inst", 64'(inst), 64'd0);
    chk("mis_err", 64'(err), 64'd1);
    fetch(0, 64'h7FFF_FFFC, inst, err, lat, acc);
    chk("low_inst", 64'(inst), 64'd0);
    chk("low_err", 64'(err), 64'd1);
    fetch(0, 64'h8000_8000, inst, err, lat, acc);
    chk("top_inst", 64'(inst), 64'd0);
    chk("top_err", 64'(err), 64'd1);
    fetch(0, 64'h8000_7FFC, inst, err, lat, acc);
    chk("last_inst", 64'(inst), 64'hA5A5A5A5);
    chk("last_err", 64'(err), 64'd0);

    step();
    resp_ready = 1'b0;
    fetch(0, 64'h8000_0004, inst, err, lat, acc);
    hold = inst;
    chk("bp_inst", 64'(hold), 64'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 64'(ov2), 64'd1);
      chk("bp_hold", 64'(in2), 64'(hold));
      chk("bp_ready", 64'(rr2), 64'd0);
    end
    resp_ready = 1'b1;
    step();
    chk("bp_done_valid", 64'(ov2), 64'd0);
    chk("bp_done_ready", 64'(rr2), 64'd1);
    chk("bp_after_inst", 64'(in2), 64'hDEADBEEF);

    req_addr = 64'h8000_0008;
    rv2 = 1'b1;
    step();
    rv2 = 1'b0;
    chk("col_busy", 64'(rr2), 64'd0);
    step();
    load_idx  = 12'd1;
    load_data = 64'h1;
    load_en   = 1'b1;
    step();
    load_en = 1'b0;
    chk("col_valid", 64'(ov2), 64'd1);
    chk("col_old", 64'(in2), 64'h12345678);
    fetch(0, 64'h8000_0008, inst, err, lat, acc);
    chk("col_new", 64'(inst), 64'h1);

    fetch(1, 64'h8000_0010, inst, err, lat, acc);
    chk("l1_inst", 64'(inst), 64'h33334444);
    chk("l1_lat", 64'(lat), 64'd1);
    fetch(2, 64'h8000_0014, inst, err, lat, acc);
    chk("l15_inst", 64'(inst), 64'h11112222);
    chk("l15_err", 64'(err), 64'd0);
    chk("l15_lat", 64'(lat), 64'd15);
    step();

    req_addr = 64'h8000_0000;
    rv2 = 1'b1;
    step();
    rv2 = 1'b0;
    step();
    chk("mid_busy", 64'(rr2), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ov2), 64'd0);
    chk("mid_rst_ready", 64'(rr2), 64'd1);
    step();
    rst = 1'b1;
    step();
    chk("mid_rel_ready", 64'(rr2), 64'd1);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      if (ov2) stale++;
      step();
    end
    chk("no_stale", 64'(stale), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
